lfsr_12_6_4_descrambler: RTL and testbench
==========================================

# lfsr_12_6_4_descrambler

Receive-side partner of the 12-bit additive scrambler (feedback taps 12/6/4/1, inverted 2→1 shift). It acquires keystream phase from a training stream, verifies alignment, then recovers payload bits by XNOR with a local keystream. It sits directly behind the serial link, one bit per accepted cycle, and reports lock status to the link controller.

## Interface
- VERIFY_LEN, 16: consecutive matching training bits required after state load before lock.
- ERR_LIMIT, 4: error-counter value that drops lock.
- clock  in  1  single rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- din  in  1  received scrambled bit.
- din_valid  in  1  din is accepted this cycle. The keystream advances only on accepted bits.
- train  in  1  link controller asserts while the far end sends payload 0 (idle/training).
- dout  out  1  descrambled bit, registered.
- dout_valid  out  1  dout is valid. Asserted only for bits accepted while LOCKED.
- locked  out  1  FSM is in LOCKED.

## Operation
- Keystream LFSR state s[1..12]. Next-state function F: s1←~s2; s2..s11←s3..s12; s12←s1^s4^s6^s12. Keystream bit k = s1. Scrambler relation: din = ~(payload ^ k). Recovery: dout = ~(din ^ k).
- During training (payload 0), the expected bit is din = ~k.
- States:
  - HUNT: on each accepted bit with train=1, shift c = ~din into 12-bit capture register C, and count captured bits 0..12.
    - Accepted bit with train=0 clears the count.
    - On the 12th capture, form S0 from captured k0..k11: s1=k0, s(j+1)=~kj for j=1..11. Load S = F^12(S0) (12-step unroll, combinational). Go to VERIFY with verify count 0.
  - VERIFY: each accepted bit with train=1 is compared against ~s1, then S←F(S).
    - Match: verify count +1. Reaching VERIFY_LEN goes to LOCKED with err counter 0.
    - Mismatch: go to HUNT, capture count 0.
    - Accepted bit with train=0 goes to HUNT.
  - LOCKED: every accepted bit outputs ~(din^s1), then S←F(S).
    - If train=1: mismatch → err+1; match → err−1, saturating at 0.
    - err reaching ERR_LIMIT goes to HUNT on that edge. The bit is still output.
- Non-accepted cycles (din_valid=0): no state, counter or LFSR change. dout holds its value; dout_valid=0.
- Counters: capture 4 bits, verify ⌈log2(VERIFY_LEN+1)⌉ bits, err ⌈log2(ERR_LIMIT+1)⌉ bits. None wrap.

## Timing
- Reset values: FSM=HUNT, S=0, C=0, all counters 0, dout=0, dout_valid=0, locked=0.
- Reset is asynchronous at any time, including mid-VERIFY or LOCKED. It returns to the values above immediately. The first accepted bit after release is the first HUNT capture.
- dout/dout_valid latency: 1 cycle after the accepting edge.
- locked rises on the edge accepting the VERIFY_LEN-th matching verify bit. Minimum 12+VERIFY_LEN accepted bits after reset, i.e. 28 by default. dout_valid first asserts for the next accepted bit.
- locked falls on the edge where err reaches ERR_LIMIT. The bit accepted on that edge gets dout_valid=1. Later bits do not.
- A train transition takes effect on the bit it accompanies. There is no pipelining of train.

## Test plan
- Reset check: hold reset_n=0 with din toggling → dout=0, dout_valid=0, locked=0. Release → still 0 until 28 accepted training bits.
- Acquisition: model scrambler from all-zero state, payload 0, train=1, din_valid=1 every cycle.
  - First 12 din are 1 followed by eleven 0s.
  - locked rises at the 28th accepted edge. The next bit gives dout=0, dout_valid=1.
- Payload recovery: after lock, train=0, payload bits 1,0,1,0,0,1,0,1 (0xA5, MSB first) → dout sequence 1,0,1,0,0,1,0,1, each one cycle after acceptance.
- Verify failure: flip din on the 5th VERIFY bit → FSM back to HUNT, locked stays 0. Relock requires 28 further accepted bits.
- Valid gaps: random din_valid duty of 50% through acquisition and payload → identical dout bit sequence as the gap-free run, and no lock loss.
- Lock loss and mid-lock reset:
  - In LOCKED with train=1, inject 4 errors with no intervening matches → locked falls on the 4th error's edge. 3 errors alternating with matches → lock held.
  - Assert reset_n mid-LOCKED → locked=0 immediately.

Source files
------------

// File: rtl/lfsr_12_6_4_descrambler_if.sv
// rtl/lfsr_12_6_4_descrambler_if.sv - serial link bundle between link controller and descrambler
//
// Purpose: carries one received bit per cycle into the descrambler and the
// recovered bit plus lock status back out.
// Signals:
//   din        received scrambled bit
//   din_valid  din is accepted this cycle
//   train      far end is sending payload 0 (idle/training)
//   dout       descrambled bit, registered
//   dout_valid dout carries a bit accepted while locked
//   locked     descrambler is locked to the keystream
// Modports: master = link controller side, slave = descrambler side.
interface lfsr_12_6_4_descrambler_if;
  logic din;
  logic din_valid;
  logic train;
  logic dout;
  logic dout_valid;
  logic locked;

  modport master (
    output din,
    output din_valid,
    output train,
    input  dout,
    input  dout_valid,
    input  locked
  );

  modport slave (
    input  din,
    input  din_valid,
    input  train,
    output dout,
    output dout_valid,
    output locked
  );
endinterface

// File: rtl/lfsr_12_6_4_descrambler.sv
// rtl/lfsr_12_6_4_descrambler.sv - 12-bit additive descrambler with training-based phase acquisition
//
// Purpose: acquires keystream phase from a training stream (payload 0),
// verifies it for VERIFY_LEN bits, then recovers payload as ~(din ^ k).
// Ports:
//   clock    rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      lfsr_12_6_4_descrambler_if.slave (din/din_valid/train in,
//            dout/dout_valid/locked out)
// Parameters:
//   VERIFY_LEN  matching training bits needed after state load before lock
//   ERR_LIMIT   error-counter value that drops lock
module lfsr_12_6_4_descrambler #(
  parameter int VERIFY_LEN = 16,
  parameter int ERR_LIMIT  = 4
) (
  input  logic                          clock,
  input  logic                          reset_n,
  lfsr_12_6_4_descrambler_if.slave      bus
);

  localparam int VW = $clog2(VERIFY_LEN + 1);
  localparam int EW = $clog2(ERR_LIMIT + 1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // One keystream step: s1 <- ~s2, s2..s11 <- s3..s12, s12 <- s1^s4^s6^s12.
  function automatic logic [12:1] lfsr_step(input logic [12:1] s);
    lfsr_step = {s[1] ^ s[4] ^ s[6] ^ s[12], s[12:3], ~s[2]};
  endfunction

  // Rebuild the state that produced keystream bits k0..k11 (k0 in bit 11).
  // Because of the inverted s2->s1 shift, k_j for j>=1 equals ~s(j+1).
  function automatic logic [12:1] seed_state(input logic [11:0] k);
    logic [12:1] s;
    s[1] = k[11];
    for (int j = 1; j <= 11; j++) begin
      s[j+1] = ~k[11-j];
    end
    seed_state = s;
  endfunction

  state_t         state_q, state_d;
  logic [12:1]    lfsr_q, lfsr_d;
  logic [11:0]    cap_q, cap_d;
  logic [3:0]     cap_cnt_q, cap_cnt_d;
  logic [VW-1:0]  ver_cnt_q, ver_cnt_d;
  logic [EW-1:0]  err_q, err_d;
  logic           dout_q, dout_d;
  logic           dout_valid_q, dout_valid_d;

  logic           key_bit;
  logic           bit_match;
  logic [11:0]    cap_full;
  logic [12:1]    seed_adv;
  logic [12:1]    lfsr_next;

  assign key_bit   = lfsr_q[1];
  // During training the line carries ~k, so a match means din == ~k.
  assign bit_match = (bus.din == ~key_bit);
  assign lfsr_next = lfsr_step(lfsr_q);
  // The 12th captured bit enters the seed on the same edge it arrives.
  assign cap_full  = {cap_q[10:0], ~bus.din};

  // S0 describes the state at the first captured bit; advance it 12 steps so
  // it lines up with the bit following the last capture.
  always_comb begin
    seed_adv = seed_state(cap_full);
    for (int i = 0; i < 12; i++) begin
      seed_adv = lfsr_step(seed_adv);
    end
  end

  always_comb begin
    state_d      = state_q;
    lfsr_d       = lfsr_q;
    cap_d        = cap_q;
    cap_cnt_d    = cap_cnt_q;
    ver_cnt_d    = ver_cnt_q;
    err_d        = err_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;

    if (bus.din_valid) begin
      unique case (state_q)
        HUNT: begin
          if (bus.train) begin
            cap_d = cap_full;
            if (cap_cnt_q == 4'd11) begin
              lfsr_d    = seed_adv;
              cap_cnt_d = 4'd0;
              ver_cnt_d = '0;
              state_d   = VERIFY;
            end else begin
              cap_cnt_d = cap_cnt_q + 4'd1;
            end
          end else begin
            cap_cnt_d = 4'd0;
          end
        end

        VERIFY: begin
          if (bus.train && bit_match) begin
            lfsr_d    = lfsr_next;
            ver_cnt_d = ver_cnt_q + 1'b1;
            if (ver_cnt_d == VW'(VERIFY_LEN)) begin
              state_d = LOCKED;
              err_d   = '0;
            end
          end else begin
            state_d   = HUNT;
            cap_cnt_d = 4'd0;
          end
        end

        LOCKED: begin
          dout_d       = ~(bus.din ^ key_bit);
          dout_valid_d = 1'b1;
          lfsr_d       = lfsr_next;
          if (bus.train) begin
            if (!bit_match) begin
              err_d = err_q + 1'b1;
            end else if (err_q != '0) begin
              err_d = err_q - 1'b1;
            end
          end
          // The bit that trips the limit is still delivered above.
          if (err_d == EW'(ERR_LIMIT)) begin
            state_d   = HUNT;
            cap_cnt_d = 4'd0;
          end
        end

        default: begin
          state_d   = HUNT;
          cap_cnt_d = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= HUNT;
      lfsr_q       <= '0;
      cap_q        <= '0;
      cap_cnt_q    <= '0;
      ver_cnt_q    <= '0;
      err_q        <= '0;
      dout_q       <= 1'b0;
      dout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      cap_q        <= cap_d;
      cap_cnt_q    <= cap_cnt_d;
      ver_cnt_q    <= ver_cnt_d;
      err_q        <= err_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.locked     = (state_q == LOCKED);

endmodule

// File: tb/tb_lfsr_12_6_4_descrambler.sv
// tb/tb_lfsr_12_6_4_descrambler.sv - self-checking bench for lfsr_12_6_4_descrambler
module tb_lfsr_12_6_4_descrambler;

  logic clock = 1'b0;
  logic reset_n = 1'b0;

  lfsr_12_6_4_descrambler_if bus ();

  lfsr_12_6_4_descrambler #(
    .VERIFY_LEN (16),
    .ERR_LIMIT  (4)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit valid;
    bit train;
    bit payload;
    bit flip;
    bit exp_locked;
  } vec_t;

  vec_t        vecs [37];
  int          n_vec = 0;
  int          n_bad = 0;
  logic [12:1] tx_s;
  bit          model_locked;
  bit          exp_dout;
  bit          sb [$];
  logic [7:0]  pay = 8'hA5;

  // Far-end scrambler keystream, written out bit by bit.
  function automatic logic [12:1] scr_next(input logic [12:1] s);
    logic [12:1] n;
    n[1] = ~s[2];
    for (int j = 2; j <= 11; j++) n[j] = s[j+1];
    n[12] = s[1] ^ s[4] ^ s[6] ^ s[12];
    return n;
  endfunction

  task automatic check(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, clock, then compare outputs 1 time unit later.
  task automatic step(input bit v, input bit t, input bit p, input bit flip, input bit exp_lock);
    bit d;
    bit want;
    if (v) begin
      d = ~(p ^ tx_s[1]) ^ flip;
      tx_s = scr_next(tx_s);
      if (model_locked) sb.push_back(p ^ flip);
    end else begin
      d = 1'($urandom);
    end
    bus.din = d;
    bus.din_valid = v;
    bus.train = t;
    @(posedge clock);
    #1;
    want = (sb.size() != 0);
    check("dout_valid", bus.dout_valid, want);
    if (want) begin
      exp_dout = sb.pop_front();
      check("dout", bus.dout, exp_dout);
    end else begin
      check("dout_hold", bus.dout, exp_dout);
    end
    check("locked", bus.locked, exp_lock);
    model_locked = exp_lock;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bus.din_valid = 1'b1;
    bus.train = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.din = i[0];
      @(posedge clock);
      #1;
      check("rst_dout", bus.dout, 1'b0);
      check("rst_dout_valid", bus.dout_valid, 1'b0);
      check("rst_locked", bus.locked, 1'b0);
    end
    reset_n = 1'b1;
    bus.din_valid = 1'b0;
    tx_s = '0;
    model_locked = 1'b0;
    exp_dout = 1'b0;
    sb.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc;
    bit v;
    bit t;
    bit p;

    bus.din = 1'b0;
    bus.din_valid = 1'b0;
    bus.train = 1'b0;
    tx_s = '0;
    #1;

    // 28 training bits to lock, one locked training bit, then payload 0xA5.
    for (int i = 0; i < 28; i++) vecs[i] = '{1'b1, 1'b1, 1'b0, 1'b0, (i >= 27)};
    vecs[28] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++) vecs[29+i] = '{1'b1, 1'b0, pay[7-i], 1'b0, 1'b1};

    do_reset();
    for (int i = 0; i < 37; i++) begin
      step(vecs[i].valid, vecs[i].train, vecs[i].payload, vecs[i].flip, vecs[i].exp_locked);
    end

    // Verify failure: 5th verify bit flipped, then 28 more bits to relock.
    do_reset();
    for (int i = 0; i < 17; i++) step(1'b1, 1'b1, 1'b0, (i == 16), 1'b0);
    for (int i = 0; i < 28; i++) step(1'b1, 1'b1, 1'b0, 1'b0, (i == 27));

    // Same acquisition and payload with ~50% din_valid gaps.
    do_reset();
    acc = 0;
    while (acc < 37) begin
      v = ($urandom_range(0, 1) == 1);
      t = (acc < 29);
      p = (acc < 29) ? 1'b0 : pay[7-(acc-29)];
      if (v) begin
        acc++;
        step(1'b1, t, p, 1'b0, (acc >= 28));
      end else begin
        step(1'b0, t, p, 1'b0, (acc >= 28));
      end
    end

    // Lock loss: alternating errors hold lock, 4 straight errors drop it.
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, (i % 2 == 0), 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b1, (i != 3));
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Relock, deliver one bit, then reset asynchronously mid-cycle.
    for (int i = 0; i < 28; i++) step(1'b1, 1'b1, 1'b0, 1'b0, (i == 27));
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_locked", bus.locked, 1'b0);
    check("async_dout_valid", bus.dout_valid, 1'b0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
